// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions two raw, bouncing, active-high push-buttons into clean signals.
// Each button has a two-flop synchronizer and then its own debounce FSM with a
// counter. A press or release is accepted only after DEBOUNCE_CYCLES
// consecutive stable synchronized samples.
//
// Parameters
//   DEBOUNCE_CYCLES : stable samples needed to accept a change (1 .. 2^CNT_W-1)
//   CNT_W           : debounce counter width in bits
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset (deassertion synchronized inside)
//   btn1, btn2 : raw asynchronous button inputs
//   btn1_press : one-cycle pulse per accepted btn1 press
//   btn2_press : one-cycle pulse per accepted btn2 press
//   btn1_level : debounced btn1 state (1 = held)
//   btn2_level : debounced btn2 state (1 = held)
//   conflict   : one-cycle pulse when both presses are accepted on one edge
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn1,
    input  logic btn2,
    output logic btn1_press,
    output logic btn2_press,
    output logic btn1_level,
    output logic btn2_level,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reset is asserted asynchronously but released on a clock edge. Its two
    // flop delay equals the input synchronizer delay, so a button held through
    // reset is seen by the FSM on the same edge it would be after power-up.
    logic [1:0] r_rst_sync;
    logic       w_rst_n_int;

    // NOTE: sequential state is always assigned with non-blocking (<=) so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n_int = r_rst_sync[1];

    logic [1:0] w_raw;
    logic [1:0] w_accept;
    logic [1:0] w_level_nxt;

    assign w_raw = {btn2, btn1};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic             r_s1;
        logic             r_s2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_acc;

        // Two-flop synchronizer; only r_s2 is used by the FSM.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
            end
        end

        always_ff @(posedge clk or negedge w_rst_n_int) begin
            if (!w_rst_n_int) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            w_acc       = 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_s2) w_state_nxt = PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!r_s2) begin
                        w_state_nxt = IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = HELD;
                        w_acc       = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!r_s2) w_state_nxt = RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    if (r_s2) begin
                        w_state_nxt = HELD;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        assign w_accept[g]    = w_acc;
        // The debounced level stays high until the release is accepted.
        assign w_level_nxt[g] = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
    end

    logic r_btn1_press;
    logic r_btn2_press;
    logic r_btn1_level;
    logic r_btn2_level;
    logic r_conflict;

    // Simultaneous accepts are reported only as a conflict, never as presses.
    always_ff @(posedge clk or negedge w_rst_n_int) begin
        if (!w_rst_n_int) begin
            r_btn1_press <= 1'b0;
            r_btn2_press <= 1'b0;
            r_btn1_level <= 1'b0;
            r_btn2_level <= 1'b0;
            r_conflict   <= 1'b0;
        end else begin
            r_btn1_press <= w_accept[0] & ~w_accept[1];
            r_btn2_press <= w_accept[1] & ~w_accept[0];
            r_btn1_level <= w_level_nxt[0];
            r_btn2_level <= w_level_nxt[1];
            r_conflict   <= &w_accept;
        end
    end

    assign btn1_press = r_btn1_press;
    assign btn2_press = r_btn2_press;
    assign btn1_level = r_btn1_level;
    assign btn2_level = r_btn2_level;
    assign conflict   = r_conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4. Edge 0 is the
// first rising edge that samples the new raw input value; acceptance is
// expected on edge 6 (DEBOUNCE_CYCLES + 2). Outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int unsigned DEB = 4;
    localparam int          ACC = DEB + 2;

    logic clk;
    logic rst_n;
    logic btn1;
    logic btn2;
    logic btn1_press;
    logic btn2_press;
    logic btn1_level;
    logic btn2_level;
    logic conflict;

    int n_checks;
    int n_fail;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (26)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn1      (btn1),
        .btn2      (btn2),
        .btn1_press(btn1_press),
        .btn2_press(btn2_press),
        .btn1_level(btn1_level),
        .btn2_level(btn2_level),
        .conflict  (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out"}, {27'd0, btn1_press, btn2_press, btn1_level, btn2_level, conflict}, 32'd0);
    endtask

    // Holds reset for a few cycles with buttons as given, then releases it
    // 1 unit after an edge; the next edge is the first post-reset edge.
    task automatic reset_dut(input logic b1, input logic b2);
        rst_n = 1'b0;
        btn1  = b1;
        btn2  = b2;
        #1;
        check_all_zero("rst_async");
        repeat (3) step();
        check_all_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    int presses;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        btn1     = 1'b0;
        btn2     = 1'b0;
        repeat (2) step();

        // btn1 held from edge 0: single pulse after edge 6, level from edge 6.
        reset_dut(1'b0, 1'b0);
        btn1 = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check("t1_press1", btn1_press, (e == ACC));
            check("t1_level1", btn1_level, (e >= ACC));
            check("t1_btn2", {btn2_press, btn2_level, conflict}, 0);
        end

        // btn2 bounces 1,1,0,1,1,0 then stays low: nothing accepted.
        reset_dut(1'b0, 1'b0);
        begin
            logic [5:0] pat;
            pat = 6'b011011;
            for (int e = 0; e < 16; e++) begin
                btn2 = (e < 6) ? pat[e] : 1'b0;
                step();
                check("t2_btn2", {btn2_press, btn2_level}, 0);
            end
        end

        // Both rise on the same edge: conflict only, both levels set.
        reset_dut(1'b0, 1'b0);
        btn1 = 1'b1;
        btn2 = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check("t3_conflict", conflict, (e == ACC));
            check("t3_presses", {btn1_press, btn2_press}, 0);
            check("t3_levels", {btn1_level, btn2_level}, (e >= ACC) ? 2'b11 : 2'b00);
        end

        // Long hold then release: one press, level falls 6 edges after release.
        reset_dut(1'b0, 1'b0);
        btn1    = 1'b1;
        presses = 0;
        for (int e = 0; e < 100; e++) begin
            step();
            if (btn1_press) presses++;
        end
        check("t4_hold_level", btn1_level, 1);
        btn1 = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            if (btn1_press) presses++;
            check("t4_rel_level", btn1_level, (e < ACC));
        end
        check("t4_press_count", presses, 1);

        // Reset in the middle of PRESS_WAIT with btn2 still held.
        reset_dut(1'b0, 1'b0);
        btn2 = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            check("t5_pre_press2", btn2_press, 0);
        end
        reset_dut(1'b0, 1'b1);
        for (int e = 0; e < 10; e++) begin
            step();
            check("t5_press2", btn2_press, (e == ACC));
            check("t5_level2", btn2_level, (e >= ACC));
        end
        // Reset mid-hold clears the level without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_level2", btn2_level, 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check("t5b_press2", btn2_press, (e == ACC));
        end

        // Held btn1, 2-cycle low glitch: level stays, no second press.
        reset_dut(1'b0, 1'b0);
        btn1 = 1'b1;
        repeat (10) step();
        check("t6_level_before", btn1_level, 1);
        btn1 = 1'b0;
        repeat (2) step();
        btn1 = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            check("t6_glitch", {btn1_press, btn1_level}, 2'b01);
        end

        // btn1 accepted while btn2 is already held: normal btn1 pulse.
        reset_dut(1'b0, 1'b0);
        btn2 = 1'b1;
        repeat (10) step();
        btn1 = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            check("t7_press1", btn1_press, (e == ACC));
            check("t7_conflict", {conflict, btn2_press, btn2_level}, 3'b001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: number of consecutive stable synchronized samples needed to accept a press or release; legal range 1 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 26: debounce counter width in bits.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port btn1  input  1: raw, asynchronous, bouncing push-button 1 (active-high).
REQ-006 Port btn2  input  1: raw, asynchronous, bouncing push-button 2 (active-high).
REQ-007 Port btn1_press  output  1: registered one-cycle pulse on each accepted btn1 press.
REQ-008 Port btn2_press  output  1: registered one-cycle pulse on each accepted btn2 press.
REQ-009 Port btn1_level  output  1: registered debounced btn1 state (1 = held).
REQ-010 Port btn2_level  output  1: registered debounced btn2 state (1 = held).
REQ-011 Port conflict  output  1: registered one-cycle pulse when both presses are accepted on the same edge.

Function
REQ-012 Each raw input SHALL pass through its own two-flop synchronizer; only the second-flop output (s2) SHALL drive the debounce logic.
REQ-013 Each button SHALL have an independent FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT and its own CNT_W-bit counter.
REQ-014 IDLE: s2=1 -> PRESS_WAIT, counter=0; otherwise stay, counter=0.
REQ-015 PRESS_WAIT: s2=0 -> IDLE, counter=0; s2=1 with counter==DEBOUNCE_CYCLES-1 -> HELD, level set, press pulse generated; else counter+1.
REQ-016 HELD: s2=0 -> RELEASE_WAIT, counter=0; s2=1 -> stay; no further press pulses, however long the button is held.
REQ-017 RELEASE_WAIT: s2=1 -> HELD, counter=0, no pulse; s2=0 with counter==DEBOUNCE_CYCLES-1 -> IDLE, level cleared; else counter+1.
REQ-018 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 Latency: with raw input stable high from the first sampling edge (edge 0), press pulse and level SHALL be high after edge DEBOUNCE_CYCLES+2.
REQ-020 Release latency SHALL be symmetric: level low after edge DEBOUNCE_CYCLES+2, counted from the first edge sampling raw low.
REQ-021 Any bounce shorter than DEBOUNCE_CYCLES stable samples SHALL produce no pulse and no level change.
REQ-022 Press pulses SHALL be exactly one clock wide.
REQ-023 If both FSMs accept a press on the same edge, btn1_press and btn2_press SHALL stay 0, conflict SHALL pulse for one cycle, and both levels SHALL still go to 1.
REQ-024 A press accepted on only one button SHALL pulse normally, whatever the other button's state.

Reset
REQ-025 rst_n=0 SHALL immediately clear synchronizers, counters, and all outputs to 0, and force both FSMs to IDLE, independent of clk.
REQ-026 Reset mid-press or mid-hold SHALL discard progress; a button still held after rst_n deasserts SHALL yield one press pulse DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
REQ-027 Reset deassertion SHALL be synchronized to clk internally before the FSMs leave reset.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 btn1 held high from edge 0 -> btn1_press=1 only in the cycle after edge 6, btn1_level=1 from edge 6 onward, btn2 outputs stay 0.
REQ-029 btn2 toggles 1,1,0,1,1,0 per cycle, then stays low -> no btn2_press, btn2_level stays 0.
REQ-030 btn1 and btn2 rise on the same edge and are held -> conflict pulses once after edge 6; btn1_press and btn2_press stay 0; both levels=1.
REQ-031 btn1 held for 100 cycles, then released -> exactly one btn1_press; btn1_level falls 6 edges after release.
REQ-032 btn2 held, rst_n pulsed low at cycle 4 of PRESS_WAIT, btn2 still held -> outputs 0 during reset; one btn2_press 6 edges after reset release.
REQ-033 btn1 held (level=1), then a 2-cycle low glitch -> btn1_level stays 1 and no second press pulse.
